// File: rtl/datapath_arbiter_pkg.sv
// Shared widths and FSM encoding for the datapath arbiter.
package datapath_arbiter_pkg;
   localparam int INSTRUCTION_WIDTH = 8;
   localparam int RESULT_WIDTH      = 8;
   localparam int THREADS_WIDTH     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } state_t;
endpackage

// File: rtl/datapath_arbiter_rr_pick.sv
// Round-robin search: first set request bit strictly after last_grant, wrapping.
module rr_pick
   import datapath_arbiter_pkg::*;
#(
   parameter int PORTS = 4
) (
   input  logic [PORTS-1:0]         req_i,
   input  logic [THREADS_WIDTH-1:0] last_grant_i,
   output logic                     found_o,
   output logic [THREADS_WIDTH-1:0] index_o
);

   always_comb begin
      int p;
      logic [PORTS-1:0] shifted;
      found_o = 1'b0;
      index_o = '0;
      p       = 0;
      shifted = '0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int off = PORTS; off >= 1; off--) begin
         p       = (int'(last_grant_i) + off) % PORTS;
         shifted = req_i >> p;
         if (shifted[0]) begin
            found_o = 1'b1;
            index_o = THREADS_WIDTH'(p);
         end
      end
   end

endmodule

// File: rtl/datapath_arbiter.sv
// Shares one datapath among PORTS requesters: round-robin grant, single
// outstanding operation, per-operation timeout with error response.
//
// state   | meaning
// IDLE    | waiting for any req_valid; grants and latches instruction
// ISSUE   | req_ready strobe visible; next edge raises dp_start
// WAIT    | datapath busy; counting towards timeout
// RESPOND | rsp_valid strobe visible for the granted port
module datapath_arbiter
   import datapath_arbiter_pkg::*;
#(
   parameter int PORTS          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [PORTS-1:0]                   req_valid,
   input  logic [PORTS*INSTRUCTION_WIDTH-1:0] req_instruction,
   output logic [PORTS-1:0]                   req_ready,
   output logic [PORTS-1:0]                   rsp_valid,
   output logic [RESULT_WIDTH-1:0]            rsp_result,
   output logic                               rsp_error,
   output logic [INSTRUCTION_WIDTH-1:0]       dp_instruction,
   output logic                               dp_start,
   input  logic [RESULT_WIDTH-1:0]            dp_result,
   input  logic                               dp_finished
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t                       state_q, state_d;
   logic [THREADS_WIDTH-1:0]     last_grant_q, last_grant_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [PORTS-1:0]             req_ready_q, req_ready_d;
   logic [PORTS-1:0]             rsp_valid_q, rsp_valid_d;
   logic [RESULT_WIDTH-1:0]      rsp_result_q, rsp_result_d;
   logic                         rsp_error_q, rsp_error_d;
   logic                         dp_start_q, dp_start_d;
   logic [INSTRUCTION_WIDTH-1:0] dp_instr_q, dp_instr_d;

   logic                         pick_found;
   logic [THREADS_WIDTH-1:0]     pick_idx;

   rr_pick #(
      .PORTS(PORTS)
   ) u_rr_pick (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .found_o      (pick_found),
      .index_o      (pick_idx)
   );

   // Strobes are registered on the transition into the state they belong to,
   // so each one is high exactly while the FSM sits in that state.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      req_ready_d  = '0;
      rsp_valid_d  = '0;
      rsp_result_d = rsp_result_q;
      rsp_error_d  = rsp_error_q;
      dp_start_d   = 1'b0;
      dp_instr_d   = dp_instr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               req_ready_d  = PORTS'(1) << pick_idx;
               dp_instr_d   = INSTRUCTION_WIDTH'(req_instruction >> (int'(pick_idx) * INSTRUCTION_WIDTH));
               last_grant_d = pick_idx;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            dp_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            // A completion arriving on the expiry cycle still counts as success.
            if (dp_finished) begin
               rsp_result_d = dp_result;
               rsp_error_d  = 1'b0;
               rsp_valid_d  = PORTS'(1) << last_grant_q;
               state_d      = ST_RESPOND;
            end else if (cnt_q == CNT_LIMIT) begin
               rsp_result_d = '0;
               rsp_error_d  = 1'b1;
               rsp_valid_d  = PORTS'(1) << last_grant_q;
               state_d      = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= THREADS_WIDTH'(PORTS - 1);
         cnt_q        <= '0;
         req_ready_q  <= '0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_error_q  <= 1'b0;
         dp_start_q   <= 1'b0;
         dp_instr_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
         dp_start_q   <= dp_start_d;
         dp_instr_q   <= dp_instr_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_result     = rsp_result_q;
   assign rsp_error      = rsp_error_q;
   assign dp_start       = dp_start_q;
   assign dp_instruction = dp_instr_q;

endmodule
